// File: rtl/timer_interrupt_controller_pkg.sv
// Shared definitions for the timer interrupt controller: flag bit positions,
// vector addresses and entry-sequence state encoding.
package timer_interrupt_controller_pkg;

  localparam int TOV0_BIT  = 0;
  localparam int OCF0_BIT  = 1;
  localparam int TOV1_BIT  = 2;
  localparam int OCF1A_BIT = 4;

  // Only these TIFR/TIMSK positions belong to timer0/timer1 sources.
  localparam logic [7:0] IRQ_MASK = 8'h17;

  localparam logic [15:0] VEC_OCF1A = 16'h000E;
  localparam logic [15:0] VEC_TOV1  = 16'h0012;
  localparam logic [15:0] VEC_OCF0  = 16'h0014;
  localparam logic [15:0] VEC_TOV0  = 16'h0016;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PUSH_L = 2'd1,
    ST_PUSH_H = 2'd2,
    ST_VECTOR = 2'd3
  } irq_state_e;

  typedef struct packed {
    logic        valid;
    logic [7:0]  flag;
    logic [15:0] vector;
  } irq_sel_t;

  function automatic irq_sel_t irq_select(input logic [7:0] req);
    irq_sel_t s;
    s = '0;
    if (req[OCF1A_BIT]) begin
      s.valid = 1'b1; s.flag[OCF1A_BIT] = 1'b1; s.vector = VEC_OCF1A;
    end else if (req[TOV1_BIT]) begin
      s.valid = 1'b1; s.flag[TOV1_BIT] = 1'b1; s.vector = VEC_TOV1;
    end else if (req[OCF0_BIT]) begin
      s.valid = 1'b1; s.flag[OCF0_BIT] = 1'b1; s.vector = VEC_OCF0;
    end else if (req[TOV0_BIT]) begin
      s.valid = 1'b1; s.flag[TOV0_BIT] = 1'b1; s.vector = VEC_TOV0;
    end
    return s;
  endfunction

endpackage

// File: rtl/timer_interrupt_controller_irq_priority_encoder.sv
// Fixed-priority selection of the pending timer interrupt: one-hot flag plus
// its vector address. Purely combinational.
module irq_priority_encoder
  import timer_interrupt_controller_pkg::*;
#(
  parameter int PC_WIDTH = 14
) (
  input  logic [7:0]          req,
  output logic                valid,
  output logic [7:0]          flag,
  output logic [PC_WIDTH-1:0] vector
);

  irq_sel_t sel;

  // Reserved positions never raise an interrupt.
  logic unused_req;
  assign unused_req = ^{req[7:5], req[3]};

  always_comb begin
    sel = irq_select(req & IRQ_MASK);
  end

  assign valid  = sel.valid;
  assign flag   = sel.flag;
  assign vector = PC_WIDTH'(sel.vector);

endmodule

// File: rtl/timer_interrupt_controller.sv
// AVR-style timer interrupt entry: pushes the return PC, clears I, acks the
// serviced flag and jumps to the vector; also re-enables I on RETI.
module timer_interrupt_controller
  import timer_interrupt_controller_pkg::*;
#(
  parameter int PC_WIDTH = 14,
  parameter int SP_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          tifr,
  input  logic [7:0]          timsk,
  input  logic                sreg_i,
  input  logic                instr_boundary,
  input  logic                reti,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [SP_WIDTH-1:0] sp,
  output logic                irq_pending,
  output logic                busy,
  output logic                mem_we,
  output logic [SP_WIDTH-1:0] mem_addr,
  output logic [7:0]          mem_data,
  output logic                sp_dec,
  output logic                pc_overwrite,
  output logic [PC_WIDTH-1:0] pc_new,
  output logic                clear_i,
  output logic                set_i,
  output logic [7:0]          tifr_clear
);

  irq_state_e          state;
  logic                inhibit;
  logic                enc_valid;
  logic [7:0]          enc_flag;
  logic [PC_WIDTH-1:0] enc_vector;
  logic [7:0]          flag_l;
  logic [PC_WIDTH-1:0] vec_l;
  logic [PC_WIDTH-1:0] pc_l;
  logic [SP_WIDTH-1:0] sp_l;
  logic [15:0]         pc_ext;
  logic                accept;

  irq_priority_encoder #(.PC_WIDTH(PC_WIDTH)) u_enc (
    .req    (tifr & timsk),
    .valid  (enc_valid),
    .flag   (enc_flag),
    .vector (enc_vector)
  );

  assign irq_pending = enc_valid;
  assign pc_ext      = 16'(pc_l);
  assign accept      = instr_boundary & sreg_i & enc_valid & ~inhibit & ~reti;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      inhibit      <= 1'b0;
      flag_l       <= '0;
      vec_l        <= '0;
      pc_l         <= '0;
      sp_l         <= '0;
      busy         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      sp_dec       <= 1'b0;
      pc_overwrite <= 1'b0;
      pc_new       <= '0;
      clear_i      <= 1'b0;
      set_i        <= 1'b0;
      tifr_clear   <= '0;
    end else begin
      busy         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      sp_dec       <= 1'b0;
      pc_overwrite <= 1'b0;
      pc_new       <= '0;
      clear_i      <= 1'b0;
      set_i        <= 1'b0;
      tifr_clear   <= '0;
      unique case (state)
        ST_IDLE: begin
          // RETI wins over a coincident boundary; the boundary that follows
          // RETI only releases the inhibit so one instruction always runs.
          if (reti) begin
            set_i   <= 1'b1;
            inhibit <= 1'b1;
          end else if (instr_boundary && inhibit) begin
            inhibit <= 1'b0;
          end else if (accept) begin
            flag_l   <= enc_flag;
            vec_l    <= enc_vector;
            pc_l     <= pc;
            sp_l     <= sp;
            state    <= ST_PUSH_L;
            busy     <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= sp;
            mem_data <= pc[7:0];
            sp_dec   <= 1'b1;
          end
        end
        ST_PUSH_L: begin
          state    <= ST_PUSH_H;
          busy     <= 1'b1;
          mem_we   <= 1'b1;
          mem_addr <= sp_l - SP_WIDTH'(1);
          mem_data <= pc_ext[15:8];
          sp_dec   <= 1'b1;
        end
        ST_PUSH_H: begin
          state        <= ST_VECTOR;
          busy         <= 1'b1;
          pc_overwrite <= 1'b1;
          pc_new       <= vec_l;
          clear_i      <= 1'b1;
          tifr_clear   <= flag_l;
        end
        ST_VECTOR: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// Directed bench for timer_interrupt_controller: entry sequence, priority,
// masking, RETI inhibit, async reset mid-sequence and stack address wrap.
module tb_timer_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tifr, timsk;
  logic        sreg_i, instr_boundary, reti;
  logic [13:0] pc;
  logic [15:0] sp;
  logic        irq_pending, busy, mem_we, sp_dec, pc_overwrite, clear_i, set_i;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, tifr_clear;
  logic [13:0] pc_new;

  int checks = 0;
  int errors = 0;

  timer_interrupt_controller #(.PC_WIDTH(14), .SP_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .tifr(tifr), .timsk(timsk), .sreg_i(sreg_i),
    .instr_boundary(instr_boundary), .reti(reti), .pc(pc), .sp(sp),
    .irq_pending(irq_pending), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .sp_dec(sp_dec), .pc_overwrite(pc_overwrite),
    .pc_new(pc_new), .clear_i(clear_i), .set_i(set_i), .tifr_clear(tifr_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] all_outs();
    return 64'({busy, mem_we, mem_addr, mem_data, sp_dec, pc_overwrite,
                pc_new, clear_i, set_i, tifr_clear});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Boundary pulse followed by the full three-cycle entry; optionally a stray
  // RETI during PUSH_L, which must be ignored.
  task automatic entry(input string tag, input logic [13:0] p, input logic [15:0] s,
                       input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] ahi,
                       input logic [13:0] ev, input logic [7:0] ef, input bit stray_reti);
    pc = p; sp = s; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    reti = stray_reti;
    chk({tag, " push_l"}, {busy, mem_we, sp_dec, pc_overwrite, clear_i, set_i, mem_addr, mem_data},
        {6'b111000, s, lo});
    tick();
    reti = 1'b0;
    chk({tag, " push_h"}, {busy, mem_we, sp_dec, pc_overwrite, clear_i, set_i, mem_addr, mem_data},
        {6'b111000, ahi, hi});
    tick();
    chk({tag, " vector"}, {busy, mem_we, sp_dec, pc_overwrite, clear_i, set_i, pc_new, tifr_clear},
        {6'b100110, ev, ef});
    tick();
    chk({tag, " idle"}, all_outs(), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; tifr = '0; timsk = '0; sreg_i = 1'b0;
    instr_boundary = 1'b0; reti = 1'b0; pc = '0; sp = '0;
    #12;
    chk("reset outs", all_outs(), 64'd0);
    chk("reset pending", {63'd0, irq_pending}, 64'd0);
    reset_n = 1'b1;
    tick();

    // TOV0 basic entry
    tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1;
    #1 chk("tov0 pending", {63'd0, irq_pending}, 64'd1);
    entry("tov0", 14'h0123, 16'h085F, 8'h23, 8'h01, 16'h085E, 14'h016, 8'h01, 1'b0);

    // Priority: all four sources pending, then timer1 masked off
    tifr = 8'h17; timsk = 8'h17;
    entry("prio ocf1a", 14'h3FFF, 16'h1000, 8'hFF, 8'h3F, 16'h0FFF, 14'h00E, 8'h10, 1'b0);
    timsk = 8'h03;
    entry("prio ocf0", 14'h0A55, 16'h0200, 8'h55, 8'h0A, 16'h01FF, 14'h014, 8'h02, 1'b1);

    // Masking: I clear, then TIMSK clear, then only reserved bits
    tifr = 8'h13; timsk = 8'h13; sreg_i = 1'b0;
    #1 chk("masked pending", {63'd0, irq_pending}, 64'd1);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("sreg_i=0 no entry", {62'd0, busy, mem_we}, 64'd0);
    sreg_i = 1'b1; timsk = 8'h00;
    #1 chk("timsk=0 pending", {63'd0, irq_pending}, 64'd0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("timsk=0 no entry", {62'd0, busy, mem_we}, 64'd0);
    tifr = 8'hE8; timsk = 8'hE8;
    #1 chk("reserved pending", {63'd0, irq_pending}, 64'd0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("reserved no entry", {62'd0, busy, mem_we}, 64'd0);

    // RETI: set_i next cycle, first boundary swallowed, second accepted
    tifr = 8'h01; timsk = 8'h01;
    reti = 1'b1; tick(); reti = 1'b0;
    chk("reti set_i", {62'd0, set_i, busy}, 64'd2);
    tick();
    chk("reti set_i pulse", {63'd0, set_i}, 64'd0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("reti first boundary", {62'd0, busy, mem_we}, 64'd0);
    tick();
    entry("after reti", 14'h0042, 16'h0100, 8'h42, 8'h00, 16'h00FF, 14'h016, 8'h01, 1'b0);

    // RETI coincident with boundary: set_i only, then inhibit still applies
    reti = 1'b1; instr_boundary = 1'b1; tick(); reti = 1'b0; instr_boundary = 1'b0;
    chk("reti+boundary", {61'd0, set_i, busy, mem_we}, 64'd4);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("reti+boundary inhibit", {62'd0, busy, mem_we}, 64'd0);
    tick();

    // Async reset during PUSH_H
    tifr = 8'h04; timsk = 8'h04; pc = 14'h0777; sp = 16'h0400;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    tick();
    chk("pre-reset push_h", {62'd0, busy, mem_we}, 64'd3);
    #2 reset_n = 1'b0;
    #1 chk("async reset outs", all_outs(), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    chk("post-reset idle", all_outs(), 64'd0);
    entry("post-reset", 14'h0777, 16'h0400, 8'h77, 8'h07, 16'h03FF, 14'h012, 8'h04, 1'b0);

    // Stack wrap at SP=0
    entry("sp wrap", 14'h0155, 16'h0000, 8'h55, 8'h01, 16'hFFFF, 14'h012, 8'h04, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_interrupt_controller.md
Name: timer_interrupt_controller

Overview:
- Consumes interrupt requests from timer0/timer1 (TIFR flags, TIMSK enables) together with the SREG I bit.
- At an instruction boundary it takes the highest-priority enabled request and runs the AVR interrupt entry: push the return PC to the stack, clear I, acknowledge (clear) the serviced TIFR flag, and overwrite the PC with the vector.
- Sits between the timers and the control unit, program memory, stack pointer and memory map.
- Also handles RETI re-enable of the I bit.

Parameters:
- PC_WIDTH, 14, program counter width in words.
- SP_WIDTH, 16, stack pointer and data address width.

Ports:
- clk  input  1  system clock (16MHz sysClock).
- reset_n  input  1  asynchronous active-low reset.
- tifr  input  8  combined TIFR flags (bit0 TOV0, bit1 OCF0, bit2 TOV1, bit4 OCF1A).
- timsk  input  8  TIMSK enables, same bit positions.
- sreg_i  input  1  SREG global interrupt enable (bit 7).
- instr_boundary  input  1  control unit pulse: current instruction completes this cycle.
- reti  input  1  control unit pulse: RETI has completed its PC pop.
- pc  input  PC_WIDTH  return address (next instruction) valid with instr_boundary.
- sp  input  SP_WIDTH  current stack pointer.
- irq_pending  output  1  combinational: any (tifr & timsk) among the supported bits.
- busy  output  1  entry sequence in progress; control unit holds fetch.
- mem_we  output  1  stack write strobe into the memory map.
- mem_addr  output  SP_WIDTH  stack write address.
- mem_data  output  8  stack write data.
- sp_dec  output  1  pulse: decrement SP by 1.
- pc_overwrite  output  1  pulse: load pc_new into the PC.
- pc_new  output  PC_WIDTH  vector address.
- clear_i  output  1  pulse: clear SREG I.
- set_i  output  1  pulse: set SREG I (RETI).
- tifr_clear  output  8  one-hot pulse: clear the serviced flag.

Behaviour:
- Reset (asynchronous, any state): state IDLE, inhibit=0. All registered outputs are 0: busy, mem_we, mem_addr, mem_data, sp_dec, pc_overwrite, pc_new, clear_i, set_i, tifr_clear.
- Priority, highest first, with vectors:
  - OCF1A (bit4) -> 0x00E
  - TOV1 (bit2) -> 0x012
  - OCF0 (bit1) -> 0x014
  - TOV0 (bit0) -> 0x016
  - Bits 3, 5, 6, 7 are ignored.
- Accept condition, evaluated in IDLE on instr_boundary: sreg_i & irq_pending & !inhibit & !reti.
  - On accept, latch the vector, the one-hot flag, pc and sp (sp_l).
  - Next state PUSH_L.
- PUSH_L (1 cycle):
  - mem_we=1, mem_addr=sp_l, mem_data=pc_l[7:0], sp_dec=1, busy=1.
  - Next state PUSH_H.
- PUSH_H (1 cycle):
  - mem_we=1, mem_addr=sp_l-1 (modulo 2^SP_WIDTH), mem_data={0, pc_l[PC_WIDTH-1:8]}, sp_dec=1, busy=1.
  - Next state VECTOR.
- VECTOR (1 cycle):
  - pc_overwrite=1, pc_new=vector, clear_i=1, tifr_clear=latched one-hot, busy=1.
  - Next state IDLE.
- Latency: accept edge to pc_overwrite is 3 cycles; busy is high for exactly 3 cycles.
- Flags are re-sampled only at the next accept. A flag that asserts during the sequence stays pending. A lower-priority flag is not lost.
- A flag deasserting after accept does not abort the sequence; the latched vector is used.
- RETI:
  - reti in IDLE gives set_i=1 the next cycle and sets inhibit=1.
  - inhibit clears on the next instr_boundary, which is itself not accepted. At least one instruction therefore executes after RETI before a new entry.
  - reti while busy is a protocol error and is ignored.
- reti and instr_boundary in the same cycle: set_i is issued, no accept.
- sp_l = 0x0000: PUSH_H address wraps to 0xFFFF.
- Outputs are pulses of one cycle only; there are no back-to-back entries without returning to IDLE.

Decomposition:
- Shared include atmega_irq_defs:
  - TIFR/TIMSK bit indices (TOV0=0, OCF0=1, TOV1=2, OCF1A=4).
  - Vector constants.
  - State encodings IDLE/PUSH_L/PUSH_H/VECTOR.
- Sub-module irq_priority_encoder (combinational):
  - Input: tifr & timsk.
  - Outputs: valid, one-hot flag, vector.
- The FSM and output registers stay in the top module.

Test Plan:
- tifr=0x01, timsk=0x01, sreg_i=1, pc=0x0123, sp=0x085F, boundary pulse:
  - PUSH_L writes 0x23 @0x085F.
  - PUSH_H writes 0x01 @0x085E.
  - sp_dec pulses twice.
  - VECTOR gives pc_new=0x016, tifr_clear=0x01, clear_i=1; busy high 3 cycles.
- tifr=0x17, timsk=0x17 -> pc_new=0x00E, tifr_clear=0x10. Repeat with timsk=0x03 -> pc_new=0x014, tifr_clear=0x02.
- sreg_i=0 or timsk=0 with tifr=0x13, boundary -> no mem_we, busy stays 0, irq_pending follows tifr&timsk.
- Flags pending, reti pulse, then boundary:
  - set_i the cycle after reti.
  - First boundary ignored.
  - Second boundary accepted (pc_overwrite 3 cycles later).
- reset_n low during PUSH_H -> all outputs 0 immediately (asynchronous). After release the block is in IDLE and re-accepts on the next boundary.
- sp=0x0000 with TOV1 pending -> writes @0x0000 and @0xFFFF, pc_new=0x012, tifr_clear=0x04.
